// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor: VGA sink that checks sync timing, locks to the frame and recovers pixel coordinates.
// Optional macro VGA_RX_CHECKSUM_EN adds frame_sum, the 16-bit wrapping sum of each locked frame's pixels.
module vga_rx_monitor #(
   parameter int H_ACT  = 640,
   parameter int H_FP   = 16,
   parameter int H_SYNC = 96,
   parameter int H_BP   = 48,
   parameter int V_ACT  = 480,
   parameter int V_FP   = 10,
   parameter int V_SYNC = 2,
   parameter int V_BP   = 33
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pix_en,
   input  logic        hs,
   input  logic        vs,
   input  logic [2:0]  red,
   input  logic [2:0]  green,
   input  logic [1:0]  blue,
   output logic        locked,
   output logic        px_valid,
   output logic [9:0]  px_x,
   output logic [9:0]  px_y,
   output logic [7:0]  px_rgb,
   output logic        frame_done,
   output logic        err_h,
   output logic        err_v,
   output logic [15:0] frame_cnt
`ifdef VGA_RX_CHECKSUM_EN
   ,
   output logic [15:0] frame_sum
`endif
);

   localparam logic [9:0] H_LAST   = 10'(H_SYNC + H_BP + H_ACT + H_FP - 1);
   localparam logic [9:0] H_RISE   = 10'(H_SYNC - 1);
   localparam logic [9:0] H_ACT_LO = 10'(H_SYNC + H_BP);
   localparam logic [9:0] H_ACT_HI = 10'(H_SYNC + H_BP + H_ACT - 1);
   localparam logic [9:0] V_LAST   = 10'(V_SYNC + V_BP + V_ACT + V_FP - 1);
   localparam logic [9:0] V_RISE   = 10'(V_SYNC);
   localparam logic [9:0] V_ACT_LO = 10'(V_SYNC + V_BP);
   localparam logic [9:0] V_ACT_HI = 10'(V_SYNC + V_BP + V_ACT - 1);

   typedef enum logic [1:0] {SEARCH = 2'd0, ALIGN = 2'd1, LOCKED = 2'd2} state_e;

   state_e     state_q;
   logic [9:0] hcnt_q, hcnt_d;
   logic [9:0] vcnt_q, vcnt_d;
   logic [9:0] v_line;
   logic       hs_q, vs_q;
   logic       hs_fall, hs_rise, vs_fall, vs_rise;
   logic       searching, err_h_c, err_v_c, err_any, active, frame_evt;

   // Checks compare the counter of the previous sample; hcnt_d/vcnt_d give this sample's position.
   always_comb begin
      hs_fall   = hs_q & ~hs;
      hs_rise   = ~hs_q & hs;
      vs_fall   = vs_q & ~vs;
      vs_rise   = ~vs_q & vs;
      searching = (state_q == SEARCH);
      v_line    = hs_fall ? vcnt_q + 10'd1 : vcnt_q;

      err_h_c = ~searching & ((hs_fall & (hcnt_q != H_LAST)) |
                              (hs_rise & (hcnt_q != H_RISE)) |
                              (~hs_fall & (hcnt_q == H_LAST)));
      err_v_c = ~searching & ((vs_fall & (vcnt_q != V_LAST)) |
                              (vs_rise & (v_line != V_RISE)));
      err_any = err_h_c | err_v_c;

      if (hs_fall || (searching && vs_fall)) begin
         hcnt_d = 10'd0;
      end else if (hcnt_q != 10'h3FF) begin
         hcnt_d = hcnt_q + 10'd1;
      end else begin
         hcnt_d = hcnt_q;
      end
      vcnt_d = vs_fall ? 10'd0 : v_line;

      active = (state_q == LOCKED) & ~err_any &
               (hcnt_d >= H_ACT_LO) & (hcnt_d <= H_ACT_HI) &
               (vcnt_d >= V_ACT_LO) & (vcnt_d <= V_ACT_HI);
      frame_evt = (state_q == LOCKED) & ~err_any & vs_fall;
   end

   // px_valid is a one-clk strobe with no back-pressure; px_x/px_y/px_rgb are stable until the next strobe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= SEARCH;
         hcnt_q     <= 10'd0;
         vcnt_q     <= 10'd0;
         hs_q       <= 1'b1;
         vs_q       <= 1'b1;
         locked     <= 1'b0;
         px_valid   <= 1'b0;
         px_x       <= 10'd0;
         px_y       <= 10'd0;
         px_rgb     <= 8'd0;
         frame_done <= 1'b0;
         err_h      <= 1'b0;
         err_v      <= 1'b0;
         frame_cnt  <= 16'd0;
      end else begin
         px_valid   <= 1'b0;
         frame_done <= 1'b0;
         err_h      <= 1'b0;
         err_v      <= 1'b0;
         if (pix_en) begin
            hs_q   <= hs;
            vs_q   <= vs;
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            err_h  <= err_h_c;
            err_v  <= err_v_c;
            if (active) begin
               px_valid <= 1'b1;
               px_x     <= hcnt_d - H_ACT_LO;
               px_y     <= vcnt_d - V_ACT_LO;
               px_rgb   <= {red, green, blue};
            end
            case (state_q)
               SEARCH: begin
                  if (vs_fall) state_q <= ALIGN;
               end
               ALIGN: begin
                  if (err_any) begin
                     state_q <= SEARCH;
                  end else if (vs_fall) begin
                     state_q <= LOCKED;
                     locked  <= 1'b1;
                  end
               end
               LOCKED: begin
                  if (err_any) begin
                     state_q <= SEARCH;
                     locked  <= 1'b0;
                  end else if (frame_evt) begin
                     frame_done <= 1'b1;
                     frame_cnt  <= frame_cnt + 16'd1;
                  end
               end
               default: begin
                  state_q <= SEARCH;
                  locked  <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef VGA_RX_CHECKSUM_EN
   logic [15:0] acc_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q     <= 16'd0;
         frame_sum <= 16'd0;
      end else if (pix_en) begin
         if (frame_evt) frame_sum <= acc_q;
         if (vs_fall || searching || err_any) begin
            acc_q <= 16'd0;
         end else if (active) begin
            acc_q <= acc_q + {8'd0, red, green, blue};
         end
      end
   end
`endif

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Bench for vga_rx_monitor on a shrunken 15x10 raster; probe table plus multi-frame lock/error/reset sequences.
module tb_vga_rx_monitor;

   localparam int H_ACT = 8, H_FP = 2, H_SYNC = 3, H_BP = 2;
   localparam int V_ACT = 4, V_FP = 2, V_SYNC = 2, V_BP = 2;
   localparam int HT = H_ACT + H_FP + H_SYNC + H_BP;
   localparam int VT = V_ACT + V_FP + V_SYNC + V_BP;
   localparam int AX0 = H_SYNC + H_BP;
   localparam int AY0 = V_SYNC + V_BP;
   localparam int NPIX = H_ACT * V_ACT;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        pix_en = 1'b0;
   logic        hs = 1'b1;
   logic        vs = 1'b1;
   logic [2:0]  red = 3'd0;
   logic [2:0]  green = 3'd0;
   logic [1:0]  blue = 2'd0;
   logic        locked, px_valid, frame_done, err_h, err_v;
   logic [9:0]  px_x, px_y;
   logic [7:0]  px_rgb;
   logic [15:0] frame_cnt;
`ifdef VGA_RX_CHECKSUM_EN
   logic [15:0] frame_sum;
`endif

   vga_rx_monitor #(
      .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .pix_en     (pix_en),
      .hs         (hs),
      .vs         (vs),
      .red        (red),
      .green      (green),
      .blue       (blue),
      .locked     (locked),
      .px_valid   (px_valid),
      .px_x       (px_x),
      .px_y       (px_y),
      .px_rgb     (px_rgb),
      .frame_done (frame_done),
      .err_h      (err_h),
      .err_v      (err_v),
      .frame_cnt  (frame_cnt)
`ifdef VGA_RX_CHECKSUM_EN
      ,
      .frame_sum  (frame_sum)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;
   int idle_bad = 0;
   int n_valid = 0, n_fd = 0, n_eh = 0, n_ev = 0;
   int cur_h = 0, cur_v = 0;
   int hs_w = H_SYNC;
   int frame_lines = VT;
   logic       sb_en = 1'b0;
   logic       use_pat = 1'b1;
   logic [7:0] fill_val = 8'h00;
   logic [27:0] exp_q[$];

   logic        s_locked, s_valid, s_fd, s_eh, s_ev;
   logic [9:0]  s_x, s_y;
   logic [7:0]  s_rgb;
   logic [15:0] s_fcnt;

   typedef struct {
      int         h;
      int         v;
      logic [7:0] rgb;
      logic       ev;
      logic [9:0] ex;
      logic [9:0] ey;
      logic [7:0] ergb;
   } probe_t;
   probe_t tbl[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic clear_counts();
      n_valid = 0; n_fd = 0; n_eh = 0; n_ev = 0;
   endtask

   // One pix_en sample followed by three idle clocks; strobes must be gone by the second idle clock.
   task automatic step(input logic h_s, input logic v_s, input logic [7:0] rgb);
      logic [27:0] e;
      @(negedge clk);
      hs = h_s; vs = v_s; {red, green, blue} = rgb; pix_en = 1'b1;
      @(negedge clk);
      pix_en = 1'b0;
      s_locked = locked; s_valid = px_valid; s_x = px_x; s_y = px_y; s_rgb = px_rgb;
      s_fd = frame_done; s_eh = err_h; s_ev = err_v; s_fcnt = frame_cnt;
      if (px_valid) n_valid++;
      if (frame_done) n_fd++;
      if (err_h) n_eh++;
      if (err_v) n_ev++;
      if (px_valid) begin
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("px_stream", 32'({px_x, px_y, px_rgb}), 32'(e));
         end else begin
            check("px_valid_extra", 32'(px_valid), 32'd0);
         end
      end
      @(negedge clk);
      if (px_valid || frame_done || err_h || err_v) idle_bad++;
      @(negedge clk);
   endtask

   task automatic ideal_next(input logic [7:0] rgb);
      logic h_s, v_s;
      h_s = (cur_h >= hs_w);
      v_s = (cur_v >= V_SYNC);
      if (sb_en && cur_h >= AX0 && cur_h < AX0 + H_ACT && cur_v >= AY0 && cur_v < AY0 + V_ACT)
         exp_q.push_back({10'(cur_h - AX0), 10'(cur_v - AY0), rgb});
      step(h_s, v_s, rgb);
      cur_h++;
      if (cur_h >= HT) begin
         cur_h = 0;
         cur_v++;
         if (cur_v >= frame_lines) cur_v = 0;
      end
   endtask

   function automatic logic [7:0] fill_rgb();
      return use_pat ? 8'((cur_h * 17 + cur_v * 29) & 255) : fill_val;
   endfunction

   task automatic run_to(input int h, input int v);
      int guard = 0;
      while (!(cur_h == h && cur_v == v)) begin
         ideal_next(fill_rgb());
         guard++;
         if (guard > 2 * HT * VT) begin
            $display("FAIL run_to: cursor never reached (%0d,%0d)", h, v);
            $fatal(1);
         end
      end
   endtask

   initial begin
      tbl[0] = '{5,  3, 8'h00, 1'b0, 10'd0, 10'd0, 8'h00};
      tbl[1] = '{4,  4, 8'h77, 1'b0, 10'd0, 10'd0, 8'h00};
      tbl[2] = '{5,  4, 8'hE3, 1'b1, 10'd0, 10'd0, 8'hE3};
      tbl[3] = '{6,  4, 8'h5A, 1'b1, 10'd1, 10'd0, 8'h5A};
      tbl[4] = '{12, 4, 8'h81, 1'b1, 10'd7, 10'd0, 8'h81};
      tbl[5] = '{13, 4, 8'hFF, 1'b0, 10'd7, 10'd0, 8'h81};
      tbl[6] = '{5,  7, 8'h3C, 1'b1, 10'd0, 10'd3, 8'h3C};
      tbl[7] = '{12, 7, 8'hC5, 1'b1, 10'd7, 10'd3, 8'hC5};
      tbl[8] = '{12, 8, 8'h11, 1'b0, 10'd7, 10'd3, 8'hC5};

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_px_valid", 32'(px_valid), 32'd0);
      check("rst_px_xy_rgb", 32'({px_x, px_y, px_rgb}), 32'd0);
      check("rst_strobes", 32'({frame_done, err_h, err_v}), 32'd0);
      check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Frame A: first sample is VS fall -> ALIGN; VS fall at its end -> LOCKED, no frame_done
      ideal_next(fill_rgb());
      check("a_start_locked", 32'(s_locked), 32'd0);
      run_to(0, 0);
      check("a_no_px", 32'(n_valid), 32'd0);
      check("a_no_err", 32'(n_eh + n_ev), 32'd0);
      ideal_next(fill_rgb());
      check("lock_vs2", 32'(s_locked), 32'd1);
      check("lock_vs2_fd", 32'(s_fd), 32'd0);
      check("lock_vs2_fcnt", 32'(s_fcnt), 32'd0);

      // Frame B: locked, probe table over active-region boundaries and hold behaviour
      clear_counts();
      sb_en = 1'b1;
      for (int i = 0; i < 9; i++) begin
         run_to(tbl[i].h, tbl[i].v);
         ideal_next(tbl[i].rgb);
         check($sformatf("probe%0d_valid", i), 32'(s_valid), 32'(tbl[i].ev));
         check($sformatf("probe%0d_x", i), 32'(s_x), 32'(tbl[i].ex));
         check($sformatf("probe%0d_y", i), 32'(s_y), 32'(tbl[i].ey));
         check($sformatf("probe%0d_rgb", i), 32'(s_rgb), 32'(tbl[i].ergb));
      end
      run_to(0, 0);
      check("b_px_count", 32'(n_valid), 32'(NPIX));
      ideal_next(fill_rgb());
      check("b_end_fd", 32'(s_fd), 32'd1);
      check("b_end_fcnt", 32'(s_fcnt), 32'd1);
      check("b_end_locked", 32'(s_locked), 32'd1);

      // Frame C: constant rgb 0x01
      clear_counts();
      use_pat = 1'b0; fill_val = 8'h01;
      run_to(0, 0);
      check("c_px_count", 32'(n_valid), 32'(NPIX));
      ideal_next(fill_rgb());
      check("c_end_fd", 32'(s_fd), 32'd1);
      check("c_end_fcnt", 32'(s_fcnt), 32'd2);
`ifdef VGA_RX_CHECKSUM_EN
      check("c_frame_sum", 32'(frame_sum), 32'(NPIX));
`endif
      check("abc_no_err", 32'(n_eh + n_ev), 32'd0);
      use_pat = 1'b1;

      // Frame D: short HS pulse on line 5 -> err_h on the rise, lock lost
      run_to(0, 5);
      hs_w = H_SYNC - 1;
      ideal_next(fill_rgb());
      ideal_next(fill_rgb());
      clear_counts();
      ideal_next(fill_rgb());
      check("hs_short_err_h", 32'(s_eh), 32'd1);
      check("hs_short_locked", 32'(s_locked), 32'd0);
      check("hs_short_err_v", 32'(s_ev), 32'd0);
      hs_w = H_SYNC;
      sb_en = 1'b0;
      run_to(0, 0);
      ideal_next(fill_rgb());
      check("d_end_fd", 32'(s_fd), 32'd0);
      check("d_end_locked", 32'(s_locked), 32'd0);
      run_to(0, 0);
      ideal_next(fill_rgb());
      check("e_relock", 32'(s_locked), 32'd1);
      check("e_relock_fd", 32'(s_fd), 32'd0);
      check("e_fcnt_kept", 32'(s_fcnt), 32'd2);
      check("de_no_px", 32'(n_valid), 32'd0);
      check("de_one_err_h", 32'(n_eh), 32'd1);

      // Frame F: one line short -> err_v on VS fall, error beats frame_done
      clear_counts();
      sb_en = 1'b1;
      frame_lines = VT - 1;
      run_to(0, 0);
      frame_lines = VT;
      check("f_px_count", 32'(n_valid), 32'(NPIX));
      ideal_next(fill_rgb());
      sb_en = 1'b0;
      check("short_frame_err_v", 32'(s_ev), 32'd1);
      check("short_frame_fd", 32'(s_fd), 32'd0);
      check("short_frame_locked", 32'(s_locked), 32'd0);
      check("short_frame_fcnt", 32'(s_fcnt), 32'd2);
      run_to(0, 0);
      ideal_next(fill_rgb());
      check("g_end_align", 32'(s_locked), 32'd0);
      run_to(0, 0);
      ideal_next(fill_rgb());
      check("h_end_locked", 32'(s_locked), 32'd1);
      check("h_end_fd", 32'(s_fd), 32'd0);

      // Frame I: asynchronous reset mid-line
      sb_en = 1'b1;
      run_to(7, 5);
      sb_en = 1'b0;
      check("pre_rst_locked", 32'(locked), 32'd1);
      check("pre_rst_fcnt", 32'(frame_cnt), 32'd2);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("async_rst_locked", 32'(locked), 32'd0);
      check("async_rst_fcnt", 32'(frame_cnt), 32'd0);
      check("async_rst_px", 32'({px_valid, px_x, px_y, px_rgb}), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      run_to(0, 0);
      ideal_next(fill_rgb());
      check("i_end_align", 32'(s_locked), 32'd0);
      run_to(0, 0);
      ideal_next(fill_rgb());
      check("j_end_locked", 32'(s_locked), 32'd1);
      check("j_end_fd", 32'(s_fd), 32'd0);
      check("j_end_fcnt", 32'(s_fcnt), 32'd0);
      clear_counts();
      sb_en = 1'b1;
      run_to(0, 0);
      ideal_next(fill_rgb());
      check("k_px_count", 32'(n_valid), 32'(NPIX));
      check("k_end_fd", 32'(s_fd), 32'd1);
      check("k_end_fcnt", 32'(s_fcnt), 32'd1);

      check("idle_strobes", 32'(idle_bad), 32'd0);
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
